clk_div_down_nbit: RTL and testbench

Programmable clock-enable divider built on a loadable down-counter. It is the counterpart to the team's free-running up-counter: it counts down from a loaded divisor, emits a one-cycle terminal-count strobe, and produces a near-50% divided clock-enable waveform. A new divisor can be requested at any time and takes effect glitch-free at the next reload, so downstream logic always sees whole periods. Sits between the control/CSR logic and any block that needs a slower tick derived from clk.

---
 rtl/clk_div_down_nbit.sv | 140 ++++++++++++++
 tb/tb_clk_div_down_nbit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_down_nbit.sv
// Programmable clock-enable divider built on a loadable down-counter with glitch-free divisor updates.
// Optional build macro CLK_DIV_ONESHOT_EN adds a oneshot input that halts the divider after one period.
module clk_div_down_nbit #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] div_value,
  input  logic                 div_load,
`ifdef CLK_DIV_ONESHOT_EN
  input  logic                 oneshot,
`endif
  output logic [CNT_WIDTH-1:0] counter,
  output logic                 tc,
  output logic                 clk_out,
  output logic                 load_pending
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  // A requested divisor of zero behaves as divide-by-one.
  function automatic logic [CNT_WIDTH-1:0] eff_n(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic [CNT_WIDTH-1:0] div_reg_q, div_reg_d;
  logic [CNT_WIDTH-1:0] pend_q, pend_d;
  logic                 load_pending_q, load_pending_d;
  logic                 tc_q, tc_d;
  logic                 clk_out_q, clk_out_d;
  logic [CNT_WIDTH-1:0] n_new;
  logic                 reload_cycle;
  logic                 do_reload;
`ifdef CLK_DIV_ONESHOT_EN
  logic                 halted_q, halted_d;
  logic                 ran_q, ran_d;
  logic                 halt_now;
  logic                 in_halt;
`endif

  always_comb begin
    counter_d      = counter_q;
    div_reg_d      = div_reg_q;
    pend_d         = pend_q;
    load_pending_d = load_pending_q;
    tc_d           = 1'b0;
    clk_out_d      = clk_out_q;
    reload_cycle   = enable && (counter_q == '0);

`ifdef CLK_DIV_ONESHOT_EN
    // Halt on the first zero reached after a real reload; a coincident load restarts instead.
    in_halt   = oneshot && halted_q;
    halt_now  = reload_cycle && oneshot && ran_q && !halted_q && !div_load;
    do_reload = reload_cycle && !in_halt && !halt_now;
`else
    do_reload = reload_cycle;
`endif

    if (div_load) begin
      n_new = eff_n(div_value);
    end else if (load_pending_q) begin
      n_new = eff_n(pend_q);
    end else begin
      n_new = div_reg_q;
    end

    if (do_reload) begin
      counter_d      = n_new - ONE;
      div_reg_d      = n_new;
      tc_d           = 1'b1;
      load_pending_d = 1'b0;
    end else begin
      if (enable && (counter_q != '0)) begin
        counter_d = counter_q - ONE;
      end
      if (div_load) begin
        pend_d         = div_value;
        load_pending_d = 1'b1;
      end
    end

    // High for the first ceil(N/2) counts of each period.
    if (enable) begin
      clk_out_d = (counter_d >= (div_reg_d >> 1));
    end

`ifdef CLK_DIV_ONESHOT_EN
    ran_d    = ran_q;
    halted_d = halted_q;
    if (do_reload) begin
      ran_d = 1'b1;
    end
    if (halt_now) begin
      ran_d    = 1'b0;
      halted_d = 1'b1;
      tc_d     = 1'b1;
    end
    if (div_load || !oneshot) begin
      halted_d = 1'b0;
    end
    if (in_halt || halt_now) begin
      clk_out_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_q      <= '0;
      div_reg_q      <= '1;
      pend_q         <= '0;
      load_pending_q <= 1'b0;
      tc_q           <= 1'b0;
      clk_out_q      <= 1'b0;
`ifdef CLK_DIV_ONESHOT_EN
      halted_q       <= 1'b0;
      ran_q          <= 1'b0;
`endif
    end else begin
      counter_q      <= counter_d;
      div_reg_q      <= div_reg_d;
      pend_q         <= pend_d;
      load_pending_q <= load_pending_d;
      tc_q           <= tc_d;
      clk_out_q      <= clk_out_d;
`ifdef CLK_DIV_ONESHOT_EN
      halted_q       <= halted_d;
      ran_q          <= ran_d;
`endif
    end
  end

  assign counter      = counter_q;
  assign tc           = tc_q;
  assign clk_out      = clk_out_q;
  assign load_pending = load_pending_q;

endmodule

// File: tb/tb_clk_div_down_nbit.sv
// Self-checking bench for clk_div_down_nbit: directed scenarios plus randomized traffic against a
// period/phase reference model.
module tb_clk_div_down_nbit;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         div_load = 1'b0;
  logic [W-1:0] div_value = '0;
  logic [W-1:0] counter;
  logic         tc;
  logic         clk_out;
  logic         load_pending;

  int checkCount = 0;
  int failCount = 0;

  // Reference model: position within the current period rather than a down-count.
  bit mStarted;
  int mPhase;
  int mN;
  int mPend[$];
  bit mTc;
  bit mClk;

  always #5 clk = ~clk;

  clk_div_down_nbit #(.CNT_WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .div_value    (div_value),
    .div_load     (div_load),
`ifdef CLK_DIV_ONESHOT_EN
    .oneshot      (1'b0),
`endif
    .counter      (counter),
    .tc           (tc),
    .clk_out      (clk_out),
    .load_pending (load_pending)
  );

  function automatic int effN(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mStarted = 1'b0;
    mPhase   = 0;
    mN       = 7;
    mPend.delete();
    mTc      = 1'b0;
    mClk     = 1'b0;
  endtask

  task automatic modelStep(input bit en, input bit ld, input int val);
    bit periodEnd;
    periodEnd = en && (!mStarted || (mPhase == mN - 1));
    if (periodEnd) begin
      if (ld) mN = effN(val);
      else if (mPend.size() > 0) mN = effN(mPend[$]);
      mPend.delete();
      mPhase   = 0;
      mStarted = 1'b1;
      mTc      = 1'b1;
      mClk     = (mPhase < (mN + 1) / 2);
    end else begin
      mTc = 1'b0;
      if (en) begin
        mPhase++;
        mClk = (mPhase < (mN + 1) / 2);
      end
      if (ld) begin
        mPend.delete();
        mPend.push_back(val);
      end
    end
  endtask

  function automatic int expCounter();
    return mStarted ? (mN - 1 - mPhase) : 0;
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, "_counter"}, int'(counter), expCounter());
    checkOutput({tag, "_tc"}, int'(tc), int'(mTc));
    checkOutput({tag, "_clk_out"}, int'(clk_out), int'(mClk));
    checkOutput({tag, "_load_pending"}, int'(load_pending), (mPend.size() > 0) ? 1 : 0);
  endtask

  task automatic applyStimulus(input bit en, input bit ld, input int val);
    @(negedge clk);
    enable    = en;
    div_load  = ld;
    div_value = val[W-1:0];
    @(posedge clk);
    modelStep(en, ld, val);
    #1;
    checkAll("step");
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n  = 1'b0;
    enable   = 1'b0;
    div_load = 1'b0;
    #1;
    modelReset();
    checkAll("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int expCnt[9] = '{6, 5, 4, 3, 2, 1, 0, 6, 5};
  int expTc[9]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
  int expClk[9] = '{1, 1, 1, 1, 0, 0, 0, 1, 1};

  initial begin
    bit found;
    int ld;
    int val;
    modelReset();

    // Free-running divide-by-7 out of reset
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, 0);
      checkOutput("tp1_counter", int'(counter), expCnt[i]);
      checkOutput("tp1_tc", int'(tc), expTc[i]);
      checkOutput("tp1_clk_out", int'(clk_out), expClk[i]);
    end

    // Load 4 while counting, applied at the next reload
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 4);
    checkOutput("tp2_pending", int'(load_pending), 1);
    checkOutput("tp2_counter", int'(counter), 2);
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("tp2_reload", int'(counter), 3);
    checkOutput("tp2_cleared", int'(load_pending), 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 0);

    // Divisors 0 and 1 both behave as divide-by-one
    applyStimulus(1'b1, 1'b1, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 0);
    checkOutput("tp3_tc0", int'(tc), 1);
    applyStimulus(1'b1, 1'b1, 1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 0);
    checkOutput("tp3_clk1", int'(clk_out), 1);

    // Enable dropped mid-period with divide-by-7
    applyStimulus(1'b1, 1'b1, 7);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 0);
    checkOutput("tp4_tc_low", int'(tc), 0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 0);

    // Load coincident with terminal count, then two overwriting loads
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (counter == '0) found = 1'b1;
      else applyStimulus(1'b1, 1'b0, 0);
    end
    checkOutput("tp5_wait", int'(found), 1);
    applyStimulus(1'b1, 1'b1, 5);
    checkOutput("tp5_counter", int'(counter), 4);
    checkOutput("tp5_pending", int'(load_pending), 0);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 2);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 0);

    // Asynchronous reset with a load pending
    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 3);
    reset_n = 1'b0;
    #2;
    modelReset();
    checkAll("tp6_async");
    @(negedge clk);
    enable   = 1'b0;
    div_load = 1'b0;
    reset_n  = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        doReset();
      end else begin
        ld  = ($urandom_range(0, 9) == 0) ? 1 : 0;
        val = $urandom_range(0, 7);
        applyStimulus(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0, ld[0], val);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
